// File: rtl/fp_align_pkg.sv
// Shared widths, operand payload type and helpers for the FP add/sub alignment path.
package fp_align_pkg;

    localparam int unsigned SIZE_EXP  = 8;
    localparam int unsigned SIZE_MAN  = 23;
    localparam int unsigned SIZE_DIFF = 5;
    localparam int unsigned DIFF_MAX  = (1 << SIZE_DIFF) - 1;

    // Unpacked FP operand as it travels between datapath blocks (hidden bit excluded).
    typedef struct packed {
        logic                sign;
        logic [SIZE_EXP-1:0] exp;
        logic [SIZE_MAN-1:0] man;
    } fp_operand_t;

    // Unsigned distance between two exponents, one bit wider so it never wraps.
    function automatic logic [SIZE_EXP:0] exp_distance(
        input logic [SIZE_EXP-1:0] exp_g,
        input logic [SIZE_EXP-1:0] exp_l
    );
        return {1'b0, exp_g} - {1'b0, exp_l};
    endfunction

endpackage

// File: rtl/fp_align_swap_pipe_mag_compare.sv
// Combinational magnitude compare: flags a < b by exponent, optionally tie-broken by mantissa.
module mag_compare #(
    parameter int unsigned SIZE_EXP = fp_align_pkg::SIZE_EXP,
    parameter int unsigned SIZE_MAN = fp_align_pkg::SIZE_MAN
) (
    input  fp_align_pkg::fp_operand_t a,
    input  fp_align_pkg::fp_operand_t b,
    input  logic                      mode,
    output logic                      less_c
);
    import fp_align_pkg::*;

    logic [SIZE_EXP-1:0] exp_a;
    logic [SIZE_EXP-1:0] exp_b;
    logic [SIZE_MAN-1:0] man_a;
    logic [SIZE_MAN-1:0] man_b;
    logic                exp_lt;
    logic                exp_eq;
    logic                man_lt;

    assign exp_a = a.exp;
    assign exp_b = b.exp;
    assign man_a = a.man;
    assign man_b = b.man;

    // Signs are ignored: ordering is by magnitude only; equal magnitudes report not-less.
    always_comb begin
        exp_lt = (exp_a < exp_b);
        exp_eq = (exp_a == exp_b);
        man_lt = (man_a < man_b);
        less_c = exp_lt | (mode & exp_eq & man_lt);
    end

endmodule

// File: rtl/fp_align_swap_pipe.sv
// Two-stage operand order/swap unit feeding the alignment shifter of the FP adder.
module fp_align_swap_pipe #(
    parameter int unsigned SIZE_EXP  = fp_align_pkg::SIZE_EXP,
    parameter int unsigned SIZE_MAN  = fp_align_pkg::SIZE_MAN,
    parameter int unsigned SIZE_DIFF = fp_align_pkg::SIZE_DIFF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_mode,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_sign_a,
    input  logic [SIZE_EXP-1:0]  i_exp_a,
    input  logic [SIZE_MAN-1:0]  i_man_a,
    input  logic                 i_sign_b,
    input  logic [SIZE_EXP-1:0]  i_exp_b,
    input  logic [SIZE_MAN-1:0]  i_man_b,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_swap,
    output logic                 o_sign_g,
    output logic [SIZE_EXP-1:0]  o_exp_g,
    output logic [SIZE_MAN-1:0]  o_man_g,
    output logic                 o_sign_l,
    output logic [SIZE_EXP-1:0]  o_exp_l,
    output logic [SIZE_MAN-1:0]  o_man_l,
    output logic [SIZE_DIFF-1:0] o_exp_diff,
    output logic                 o_diff_sat
);
    import fp_align_pkg::*;

    localparam int unsigned     RAW_W     = SIZE_EXP + 1;
    localparam logic [RAW_W-1:0] SAT_LIMIT = RAW_W'((1 << SIZE_DIFF) - 1);

    fp_operand_t            op_a;
    fp_operand_t            op_b;
    fp_operand_t            great_c;
    fp_operand_t            lesser_c;
    logic                   swap_c;
    logic [RAW_W-1:0]       raw_diff_c;

    logic                   stage2_en_c;
    logic                   stage1_en_c;

    logic                   v1;
    logic                   swap1;
    fp_operand_t            great1;
    fp_operand_t            lesser1;
    logic [RAW_W-1:0]       raw_diff1;

    logic                   sat_c;
    logic [SIZE_DIFF-1:0]   diff_sat_c;

    logic                   v2;
    logic                   swap2;
    fp_operand_t            great2;
    fp_operand_t            lesser2;
    logic [SIZE_DIFF-1:0]   diff2;
    logic                   sat2;

    assign op_a = '{sign: i_sign_a, exp: i_exp_a, man: i_man_a};
    assign op_b = '{sign: i_sign_b, exp: i_exp_b, man: i_man_b};

    // B strictly greater than A means the operands are exchanged.
    mag_compare #(
        .SIZE_EXP (SIZE_EXP),
        .SIZE_MAN (SIZE_MAN)
    ) u_mag_compare (
        .a      (op_a),
        .b      (op_b),
        .mode   (i_mode),
        .less_c (swap_c)
    );

    // Order operands and take the exponent distance; a mantissa-only swap leaves it at zero.
    always_comb begin
        great_c    = swap_c ? op_b : op_a;
        lesser_c   = swap_c ? op_a : op_b;
        raw_diff_c = exp_distance(great_c.exp, lesser_c.exp);
    end

    // Stage enables: each stage moves when its successor is empty or draining.
    always_comb begin
        stage2_en_c = ~v2 | i_ready;
        stage1_en_c = ~v1 | stage2_en_c;
    end

    assign o_ready = stage1_en_c;

    // Stage 1 capture of ordered operands, raw distance and swap flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v1        <= 1'b0;
            swap1     <= 1'b0;
            great1    <= '0;
            lesser1   <= '0;
            raw_diff1 <= '0;
        end else if (stage1_en_c) begin
            v1 <= i_valid;
            if (i_valid) begin
                swap1     <= swap_c;
                great1    <= great_c;
                lesser1   <= lesser_c;
                raw_diff1 <= raw_diff_c;
            end
        end
    end

    // Clamp the distance to what the shifter control field can express.
    always_comb begin
        sat_c      = (raw_diff1 > SAT_LIMIT);
        diff_sat_c = sat_c ? SIZE_DIFF'(SAT_LIMIT) : raw_diff1[SIZE_DIFF-1:0];
    end

    // Stage 2 output registers; hold while downstream stalls.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v2      <= 1'b0;
            swap2   <= 1'b0;
            great2  <= '0;
            lesser2 <= '0;
            diff2   <= '0;
            sat2    <= 1'b0;
        end else if (stage2_en_c) begin
            v2 <= v1;
            if (v1) begin
                swap2   <= swap1;
                great2  <= great1;
                lesser2 <= lesser1;
                diff2   <= diff_sat_c;
                sat2    <= sat_c;
            end
        end
    end

    assign o_valid    = v2;
    assign o_swap     = swap2;
    assign o_sign_g   = great2.sign;
    assign o_exp_g    = great2.exp;
    assign o_man_g    = great2.man;
    assign o_sign_l   = lesser2.sign;
    assign o_exp_l    = lesser2.exp;
    assign o_man_l    = lesser2.man;
    assign o_exp_diff = diff2;
    assign o_diff_sat = sat2;

endmodule
